// File: rtl/featuremap_layer_sched_pkg.sv
// Shared featuremap constants: frame padding, scheduler state encoding and
// derived frame sizes/counter widths.
package featuremap_layer_sched_pkg;

    localparam int unsigned PAD = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fm_state_e;

    function automatic int unsigned fm_in_total(input int unsigned width);
        return (width + PAD) * (width + PAD);
    endfunction

    function automatic int unsigned fm_out_total(input int unsigned width);
        return width * width;
    endfunction

    function automatic int unsigned fm_cnt_width(input int unsigned width);
        return $clog2(fm_in_total(width) + 1);
    endfunction

endpackage

// File: rtl/featuremap_layer_sched.sv
// Frame scheduler for one featuremap filter bank: issues the padded input
// frame under backpressure, counts results, and flags overrun/drain timeout.
module featuremap_layer_sched
    import featuremap_layer_sched_pkg::*;
#(
    parameter int unsigned WIDTH         = 56,
    parameter int unsigned NUM_CH        = 16,
    parameter int unsigned DRAIN_TIMEOUT = 4096,
    localparam int unsigned CW           = fm_cnt_width(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_empty,
    input  logic              out_afull,
    input  logic              fm_valid_out,
    output logic              fm_valid_in,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     in_count,
    output logic [CW-1:0]     out_count,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam int unsigned   DW         = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CW-1:0] IN_TOTAL   = CW'(fm_in_total(WIDTH));
    localparam logic [CW-1:0] OUT_TOTAL  = CW'(fm_out_total(WIDTH));
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

    fm_state_e     state_q, state_d;
    logic [CW-1:0] in_count_q, in_count_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          err_overrun_q, err_overrun_d;
    logic          err_timeout_q, err_timeout_d;

    logic all_ready;
    logic active;
    logic out_accept;
    logic out_done;

    assign all_ready   = ~|ch_empty;
    assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign fm_valid_in = (state_q == ST_RUN) && all_ready && !out_afull &&
                         (in_count_q < IN_TOTAL);
    assign out_accept  = fm_valid_out && active && (out_count_q < OUT_TOTAL);
    // Completion also covers the cycle in which the last result is being counted.
    assign out_done    = (out_count_q == OUT_TOTAL) ||
                         (out_accept && (out_count_q == OUT_TOTAL - CW'(1)));

    always_comb begin
        state_d       = state_q;
        in_count_d    = in_count_q;
        out_count_d   = out_count_q;
        drain_cnt_d   = drain_cnt_q;
        err_overrun_d = err_overrun_q;
        err_timeout_d = err_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_RUN;
                    in_count_d    = '0;
                    out_count_d   = '0;
                    err_overrun_d = 1'b0;
                    err_timeout_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (fm_valid_in) begin
                    in_count_d = in_count_q + CW'(1);
                    if (in_count_q == IN_TOTAL - CW'(1)) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_done) begin
                    state_d = ST_DONE;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d       = ST_DONE;
                    err_timeout_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An unexpected result in the same cycle as an accepted start still counts as overrun.
        if (out_accept) begin
            out_count_d = out_count_q + CW'(1);
        end else if (fm_valid_out) begin
            err_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_count_q    <= '0;
            out_count_q   <= '0;
            drain_cnt_q   <= '0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_count_q    <= in_count_d;
            out_count_q   <= out_count_d;
            drain_cnt_q   <= drain_cnt_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign busy        = active;
    assign done        = (state_q == ST_DONE);
    assign in_count    = in_count_q;
    assign out_count   = out_count_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_featuremap_layer_sched.sv
// Bench for featuremap_layer_sched: fixed vector table, directed frame
// scenarios and random traffic against a frame-level reference model.
module tb_featuremap_layer_sched;

    localparam int unsigned W     = 4;
    localparam int unsigned NCH   = 16;
    localparam int unsigned DT    = 50;
    localparam int unsigned IN_T  = 36;
    localparam int unsigned OUT_T = 16;
    localparam int unsigned CW    = $clog2(IN_T + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1, start = 1'b0, out_afull = 1'b0, fm_valid_out = 1'b0;
    logic [NCH-1:0] ch_empty = '0;
    logic           fm_valid_in, busy, done, err_overrun, err_timeout;
    logic [CW-1:0]  in_count, out_count;

    featuremap_layer_sched #(
        .WIDTH(W),
        .NUM_CH(NCH),
        .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ch_empty(ch_empty),
        .out_afull(out_afull),
        .fm_valid_out(fm_valid_out),
        .fm_valid_in(fm_valid_in),
        .busy(busy),
        .done(done),
        .in_count(in_count),
        .out_count(out_count),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    bit chk_model = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame-level reference: a frame is active, pixels issued, results received,
    // and how long it has waited for results once every pixel is out.
    bit m_frame = 0, m_done = 0, m_ovr = 0, m_tmo = 0;
    int m_issued = 0, m_recv = 0, m_drain = 0;

    function automatic bit m_vi(input logic [NCH-1:0] e, input bit af);
        return m_frame && (m_issued < IN_T) && (e == '0) && !af;
    endfunction

    task automatic model_edge(input bit r, input bit s, input logic [NCH-1:0] e,
                              input bit af, input bit vo);
        bit vi, act, idle;
        if (r) begin
            m_frame = 0; m_done = 0; m_ovr = 0; m_tmo = 0;
            m_issued = 0; m_recv = 0; m_drain = 0;
            return;
        end
        vi   = m_vi(e, af);
        act  = m_frame;
        idle = !m_frame && !m_done;
        m_done = 0;
        if (idle && s) begin
            m_frame = 1; m_issued = 0; m_recv = 0; m_ovr = 0; m_tmo = 0;
        end
        if (vo) begin
            if (act && m_recv < OUT_T) m_recv++;
            else m_ovr = 1;
        end
        if (act) begin
            if (m_issued < IN_T) begin
                if (vi) begin
                    m_issued++;
                    if (m_issued == IN_T) m_drain = 0;
                end
            end else if (m_recv == OUT_T) begin
                m_frame = 0; m_done = 1;
            end else if (m_drain == DT - 1) begin
                m_tmo = 1; m_frame = 0; m_done = 1;
            end else begin
                m_drain++;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input logic [NCH-1:0] e,
                        input bit af, input bit vo, output bit vi_seen);
        rst = r; start = s; ch_empty = e; out_afull = af; fm_valid_out = vo;
        #1;
        vi_seen = fm_valid_in;
        if (chk_model) check("m_fm_valid_in", int'(fm_valid_in), int'(m_vi(e, af)));
        @(posedge clk);
        model_edge(r, s, e, af, vo);
        #1;
        if (done) done_cnt++;
        if (chk_model) begin
            check("m_busy", int'(busy), int'(m_frame));
            check("m_done", int'(done), int'(m_done));
            check("m_in_count", int'(in_count), m_issued);
            check("m_out_count", int'(out_count), m_recv);
            check("m_err_overrun", int'(err_overrun), int'(m_ovr));
            check("m_err_timeout", int'(err_timeout), int'(m_tmo));
        end
    endtask

    task automatic idle_step();
        bit v;
        step(0, 0, '0, 0, 0, v);
    endtask

    task automatic full_frame(input string tag);
        bit v;
        int nvi;
        done_cnt = 0;
        nvi = 0;
        step(0, 1, '0, 0, 0, v);
        for (int k = 0; k < IN_T; k++) begin
            step(0, 0, '0, 0, 0, v);
            nvi += int'(v);
        end
        check({tag, "_vi_cycles"}, nvi, 36);
        for (int k = 0; k < OUT_T; k++) step(0, 0, '0, 0, 1, v);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_in_count"}, int'(in_count), 36);
        check({tag, "_out_count"}, int'(out_count), 16);
        check({tag, "_err_overrun"}, int'(err_overrun), 0);
        check({tag, "_err_timeout"}, int'(err_timeout), 0);
        idle_step();
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_in_hold"}, int'(in_count), 36);
    endtask

    typedef struct {
        bit r, s, e, af, vo;
        bit vi, bsy, dn;
        int inc, outc;
        bit ovr, tmo;
    } vec_t;

    vec_t tbl[11];

    initial begin
        bit v;
        int k, n, nvi;
        logic [NCH-1:0] e;
        bit af;

        //          r  s  e af vo   vi bsy dn inc outc ovr tmo
        tbl[0]  = '{1, 0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0};
        tbl[1]  = '{0, 0, 0, 0, 1,  0, 0,  0, 0,  0,   1,  0};
        tbl[2]  = '{0, 0, 0, 0, 0,  0, 0,  0, 0,  0,   1,  0};
        tbl[3]  = '{0, 1, 0, 0, 0,  0, 1,  0, 0,  0,   0,  0};
        tbl[4]  = '{0, 0, 0, 0, 0,  1, 1,  0, 1,  0,   0,  0};
        tbl[5]  = '{0, 0, 1, 0, 0,  0, 1,  0, 1,  0,   0,  0};
        tbl[6]  = '{0, 0, 0, 1, 0,  0, 1,  0, 1,  0,   0,  0};
        tbl[7]  = '{0, 0, 0, 0, 1,  1, 1,  0, 2,  1,   0,  0};
        tbl[8]  = '{0, 1, 0, 0, 0,  1, 1,  0, 3,  1,   0,  0};
        tbl[9]  = '{1, 0, 0, 0, 0,  1, 0,  0, 0,  0,   0,  0};
        tbl[10] = '{0, 0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0};

        @(negedge clk);
        step(1, 0, '0, 0, 0, v);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            e = '0;
            e[7] = tbl[i].e;
            step(tbl[i].r, tbl[i].s, e, tbl[i].af, tbl[i].vo, v);
            check($sformatf("tbl%0d_vi", i), int'(v), int'(tbl[i].vi));
            check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bsy));
            check($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].dn));
            check($sformatf("tbl%0d_in", i), int'(in_count), tbl[i].inc);
            check($sformatf("tbl%0d_out", i), int'(out_count), tbl[i].outc);
            check($sformatf("tbl%0d_ovr", i), int'(err_overrun), int'(tbl[i].ovr));
            check($sformatf("tbl%0d_tmo", i), int'(err_timeout), int'(tbl[i].tmo));
        end

        chk_model = 1'b1;

        // Nominal frame
        full_frame("nom");

        // Stall: channel 7 empty for RUN cycles 10-14, then out_afull for 3 cycles
        step(0, 1, '0, 0, 0, v);
        k = 0; nvi = 0;
        while (nvi < 36 && k < 100) begin
            e = '0;
            if (k >= 10 && k <= 14) e[7] = 1'b1;
            af = (k >= 15 && k <= 17);
            step(0, 0, e, af, 0, v);
            check($sformatf("stall_vi_k%0d", k), int'(v), int'(!(k >= 10 && k <= 17)));
            nvi += int'(v);
            k++;
        end
        check("stall_run_cycles", k, 44);
        for (int j = 0; j < OUT_T; j++) step(0, 0, '0, 0, 1, v);
        check("stall_done", int'(done), 1);
        check("stall_in_count", int'(in_count), 36);
        idle_step();

        // Timeout: only 15 results
        done_cnt = 0;
        step(0, 1, '0, 0, 0, v);
        for (int j = 0; j < IN_T; j++) idle_step();
        for (int j = 0; j < 15; j++) step(0, 0, '0, 0, 1, v);
        n = 15;
        while (!done && n < 100) begin
            idle_step();
            n++;
        end
        check("tmo_drain_cycles", n, 50);
        check("tmo_err_timeout", int'(err_timeout), 1);
        check("tmo_out_count", int'(out_count), 15);
        check("tmo_done_pulses", done_cnt, 1);
        idle_step();
        check("tmo_err_hold", int'(err_timeout), 1);

        // Overrun in IDLE, cleared by the next start
        step(0, 0, '0, 0, 1, v);
        check("ovr_set", int'(err_overrun), 1);
        step(0, 1, '0, 0, 0, v);
        check("ovr_cleared", int'(err_overrun), 0);
        check("ovr_tmo_cleared", int'(err_timeout), 0);

        // Reset abort with in_count at 20
        k = 0;
        while (m_issued < 20 && k < 100) begin
            idle_step();
            k++;
        end
        check("abort_reached_20", int'(in_count), 20);
        done_cnt = 0;
        step(1, 0, '0, 0, 0, v);
        check("abort_busy", int'(busy), 0);
        check("abort_in_count", int'(in_count), 0);
        check("abort_out_count", int'(out_count), 0);
        for (int j = 0; j < 5; j++) idle_step();
        check("abort_no_done", done_cnt, 0);
        full_frame("post_abort");

        // start held high: one frame per IDLE visit
        done_cnt = 0;
        n = 0;
        step(0, 1, '0, 0, 0, v);
        while (!done && n < 200) begin
            step(0, 1, '0, 0, m_frame && (m_issued == IN_T), v);
            n++;
        end
        check("held_done_seen", int'(done), 1);
        check("held_done_pulses", done_cnt, 1);
        step(0, 1, '0, 0, 0, v);
        check("held_idle_busy", int'(busy), 0);
        step(0, 1, '0, 0, 0, v);
        check("held_restart_busy", int'(busy), 1);
        check("held_restart_in", int'(in_count), 0);
        step(1, 0, '0, 0, 0, v);

        // Random traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            e = '0;
            if ($urandom_range(0, 5) == 0) e[$urandom_range(0, NCH - 1)] = 1'b1;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) == 0,
                 e,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) == 0,
                 v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
